// File: rtl/dmem_req.sv
// Data-memory request unit: turns EX-stage load/store ops into single-outstanding bus requests.
// Optional LL/SC support is enabled by defining DMEM_LLSC_EN.
module dmem_req #(
    parameter int unsigned ALUOP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        reg2_i,
    input  logic               llbit_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               stall_o,
    output logic               data_req_o,
    output logic               data_wr_o,
    output logic [1:0]         data_size_o,
    output logic [31:0]        data_addr_o,
    output logic [3:0]         data_wstrb_o,
    output logic [31:0]        data_wdata_o,
    input  logic               data_addr_ok_i,
    input  logic               data_data_ok_i,
    input  logic [31:0]        data_rdata_i,
    output logic               resp_valid_o,
    output logic [31:0]        mem_data_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        excepttype_o,
    output logic               sc_result_o
);

    localparam logic [ALUOP_W-1:0] OpLb  = ALUOP_W'(8'hE0);
    localparam logic [ALUOP_W-1:0] OpLbu = ALUOP_W'(8'hE4);
    localparam logic [ALUOP_W-1:0] OpLh  = ALUOP_W'(8'hE1);
    localparam logic [ALUOP_W-1:0] OpLhu = ALUOP_W'(8'hE5);
    localparam logic [ALUOP_W-1:0] OpLw  = ALUOP_W'(8'hE3);
    localparam logic [ALUOP_W-1:0] OpLwl = ALUOP_W'(8'hE2);
    localparam logic [ALUOP_W-1:0] OpLwr = ALUOP_W'(8'hE6);
    localparam logic [ALUOP_W-1:0] OpLl  = ALUOP_W'(8'hF0);
    localparam logic [ALUOP_W-1:0] OpSb  = ALUOP_W'(8'hE8);
    localparam logic [ALUOP_W-1:0] OpSh  = ALUOP_W'(8'hE9);
    localparam logic [ALUOP_W-1:0] OpSw  = ALUOP_W'(8'hEB);
    localparam logic [ALUOP_W-1:0] OpSwl = ALUOP_W'(8'hEA);
    localparam logic [ALUOP_W-1:0] OpSwr = ALUOP_W'(8'hEE);
    localparam logic [ALUOP_W-1:0] OpSc  = ALUOP_W'(8'hF8);

    localparam logic [31:0] ExcAdel = 32'h0000_0010;
    localparam logic [31:0] ExcAdes = 32'h0000_0020;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

    state_e state_q, state_d;

    // Decoded view of the op currently on the EX inputs
    logic        is_load, is_store, is_sc, misaligned, sc_fail;
    logic [1:0]  size_n;
    logic [31:0] baddr_n;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;

    logic        start, early_resp, resp_fire;

    // Captured transaction
    logic        wr_q, load_q, sc_q;
    logic [1:0]  size_q;
    logic [31:0] baddr_q, wdata_q, oaddr_q;
    logic [3:0]  wstrb_q;

    logic        resp_valid_q, sc_result_q;
    logic [31:0] mem_data_q, mem_addr_q, exc_q;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_sc      = 1'b0;
        misaligned = 1'b0;
        size_n     = 2'd2;
        baddr_n    = addr_i;
        wstrb_n    = 4'b0000;
        wdata_n    = 32'h0;
        case (aluop_i)
            OpLb, OpLbu: begin
                is_load = 1'b1;
                size_n  = 2'd0;
            end
            OpLh, OpLhu: begin
                is_load    = 1'b1;
                size_n     = 2'd1;
                misaligned = addr_i[0];
            end
            OpLw, OpLl: begin
                is_load    = 1'b1;
                misaligned = |addr_i[1:0];
            end
            OpLwl, OpLwr: begin
                is_load = 1'b1;
                baddr_n = {addr_i[31:2], 2'b00};
            end
            OpSb: begin
                is_store = 1'b1;
                size_n   = 2'd0;
                wstrb_n  = 4'b0001 << addr_i[1:0];
                wdata_n  = {4{reg2_i[7:0]}};
            end
            OpSh: begin
                is_store   = 1'b1;
                size_n     = 2'd1;
                misaligned = addr_i[0];
                wstrb_n    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{reg2_i[15:0]}};
            end
            OpSw, OpSc: begin
                is_store   = 1'b1;
                is_sc      = (aluop_i == OpSc);
                misaligned = |addr_i[1:0];
                wstrb_n    = 4'b1111;
                wdata_n    = reg2_i;
            end
            OpSwl: begin
                is_store = 1'b1;
                baddr_n  = {addr_i[31:2], 2'b00};
                case (addr_i[1:0])
                    2'b00:   begin wstrb_n = 4'b0001; wdata_n = {24'h0, reg2_i[31:24]}; end
                    2'b01:   begin wstrb_n = 4'b0011; wdata_n = {16'h0, reg2_i[31:16]}; end
                    2'b10:   begin wstrb_n = 4'b0111; wdata_n = {8'h0, reg2_i[31:8]}; end
                    default: begin wstrb_n = 4'b1111; wdata_n = reg2_i; end
                endcase
            end
            OpSwr: begin
                is_store = 1'b1;
                baddr_n  = {addr_i[31:2], 2'b00};
                case (addr_i[1:0])
                    2'b00:   begin wstrb_n = 4'b1111; wdata_n = reg2_i; end
                    2'b01:   begin wstrb_n = 4'b1110; wdata_n = {reg2_i[23:0], 8'h0}; end
                    2'b10:   begin wstrb_n = 4'b1100; wdata_n = {reg2_i[15:0], 16'h0}; end
                    default: begin wstrb_n = 4'b1000; wdata_n = {reg2_i[7:0], 24'h0}; end
                endcase
            end
            default: ;
        endcase
    end

`ifdef DMEM_LLSC_EN
    // A failed SC is answered locally without touching the bus
    assign sc_fail = is_sc & ~llbit_i;
`else
    logic unused_llbit;
    assign unused_llbit = llbit_i;
    assign sc_fail      = 1'b0;
`endif

    always_comb begin
        start      = 1'b0;
        early_resp = 1'b0;
        if (state_q == StIdle && valid_i && !flush_i && (is_load || is_store)) begin
            if (misaligned || sc_fail) early_resp = 1'b1;
            else                       start      = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        resp_fire = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StReq;
            end
            StReq: begin
                if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        state_d   = StIdle;
                        resp_fire = ~flush_i;
                    end else begin
                        // Bus already owns the request, so a flush must still absorb data_ok
                        state_d = flush_i ? StDrain : StWait;
                    end
                end else if (flush_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (data_data_ok_i) begin
                    state_d   = StIdle;
                    resp_fire = ~flush_i;
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (data_data_ok_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_q         <= 1'b0;
            load_q       <= 1'b0;
            sc_q         <= 1'b0;
            size_q       <= 2'd0;
            baddr_q      <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'b0000;
            oaddr_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            sc_result_q  <= 1'b0;
            mem_data_q   <= 32'h0;
            mem_addr_q   <= 32'h0;
            exc_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_fire | early_resp;
            if (start) begin
                wr_q    <= is_store;
                load_q  <= is_load;
                sc_q    <= is_sc;
                size_q  <= size_n;
                baddr_q <= baddr_n;
                wdata_q <= wdata_n;
                wstrb_q <= wstrb_n;
                oaddr_q <= addr_i;
            end
            if (resp_fire) begin
                mem_data_q  <= load_q ? data_rdata_i : 32'h0;
                mem_addr_q  <= oaddr_q;
                exc_q       <= 32'h0;
                sc_result_q <= sc_q;
            end else if (early_resp) begin
                mem_data_q  <= 32'h0;
                mem_addr_q  <= addr_i;
                exc_q       <= misaligned ? (is_load ? ExcAdel : ExcAdes) : 32'h0;
                sc_result_q <= 1'b0;
            end
        end
    end

    assign ready_o      = (start | early_resp) & ~rst;
    assign stall_o      = ((state_q != StIdle) | start) & ~rst;
    assign data_req_o   = (state_q == StReq) & ~rst;
    assign data_wr_o    = wr_q;
    assign data_size_o  = size_q;
    assign data_addr_o  = baddr_q;
    assign data_wstrb_o = wstrb_q;
    assign data_wdata_o = wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign mem_data_o   = mem_data_q;
    assign mem_addr_o   = mem_addr_q;
    assign excepttype_o = exc_q;
    assign sc_result_o  = sc_result_q;

endmodule

// File: tb/tb_dmem_req.sv
// Directed bench for dmem_req: table of single-op vectors plus hand-written multi-cycle sequences.
// Honours DMEM_LLSC_EN for the SC-fail sequence.
module tb_dmem_req;

    localparam logic [7:0] OpLb = 8'hE0, OpLbu = 8'hE4, OpLh = 8'hE1, OpLhu = 8'hE5;
    localparam logic [7:0] OpLw = 8'hE3, OpLwl = 8'hE2, OpSb = 8'hE8, OpSh = 8'hE9;
    localparam logic [7:0] OpSw = 8'hEB, OpSwl = 8'hEA, OpSwr = 8'hEE, OpSc = 8'hF8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid = 1'b0, llbit = 1'b1, flush = 1'b0;
    logic [7:0]  aluop = 8'h00;
    logic [31:0] addr = 32'h0, reg2 = 32'h0, rdata = 32'h0;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic        ready, stall, data_req, data_wr, resp_valid, sc_result;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, mem_data, mem_addr, excepttype;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_req #(.ALUOP_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid), .aluop_i(aluop), .addr_i(addr), .reg2_i(reg2),
        .llbit_i(llbit), .flush_i(flush), .ready_o(ready), .stall_o(stall),
        .data_req_o(data_req), .data_wr_o(data_wr), .data_size_o(data_size),
        .data_addr_o(data_addr), .data_wstrb_o(data_wstrb), .data_wdata_o(data_wdata),
        .data_addr_ok_i(addr_ok), .data_data_ok_i(data_ok), .data_rdata_i(rdata),
        .resp_valid_o(resp_valid), .mem_data_o(mem_data), .mem_addr_o(mem_addr),
        .excepttype_o(excepttype), .sc_result_o(sc_result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rt);
        cyc();
        valid = 1'b1;
        aluop = op;
        addr  = a;
        reg2  = rt;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] exc;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] baddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] mdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{OpSb,  32'h1003, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 32'h0,  1, 2'd0,
                     32'h1003, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{OpLw,  32'h2002, 32'h0, 32'h0, 1, 32'h10, 0, 2'd0,
                     32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[2]  = '{OpSwr, 32'h3001, 32'h1122_3344, 32'hFFFF_FFFF, 0, 32'h0, 1, 2'd2,
                     32'h3000, 4'b1110, 32'h2233_4400, 32'h0};
        vecs[3]  = '{OpLh,  32'h4002, 32'h0, 32'h1234_5678, 0, 32'h0, 0, 2'd1,
                     32'h4002, 4'b0000, 32'h0, 32'h1234_5678};
        vecs[4]  = '{OpSh,  32'h5002, 32'hCAFE_BEEF, 32'h1, 0, 32'h0, 1, 2'd1,
                     32'h5002, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[5]  = '{OpSwl, 32'h6001, 32'h1122_3344, 32'h1, 0, 32'h0, 1, 2'd2,
                     32'h6000, 4'b0011, 32'h0000_1122, 32'h0};
        vecs[6]  = '{OpSwl, 32'h6002, 32'h1122_3344, 32'h1, 0, 32'h0, 1, 2'd2,
                     32'h6000, 4'b0111, 32'h0011_2233, 32'h0};
        vecs[7]  = '{OpSwr, 32'h6003, 32'h1122_3344, 32'h1, 0, 32'h0, 1, 2'd2,
                     32'h6000, 4'b1000, 32'h4400_0000, 32'h0};
        vecs[8]  = '{OpLwl, 32'h7003, 32'h0, 32'hA5A5_5A5A, 0, 32'h0, 0, 2'd2,
                     32'h7000, 4'b0000, 32'h0, 32'hA5A5_5A5A};
        vecs[9]  = '{OpSh,  32'h5001, 32'h0, 32'h0, 1, 32'h20, 0, 2'd0,
                     32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{OpLbu, 32'h8001, 32'h0, 32'h0000_FF00, 0, 32'h0, 0, 2'd0,
                     32'h8001, 4'b0000, 32'h0, 32'h0000_FF00};
        vecs[11] = '{OpSw,  32'h9004, 32'h0102_0304, 32'h5, 0, 32'h0, 1, 2'd2,
                     32'h9004, 4'b1111, 32'h0102_0304, 32'h0};
        vecs[12] = '{OpLhu, 32'h0003, 32'h0, 32'h0, 1, 32'h10, 0, 2'd0,
                     32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[13] = '{OpSc,  32'hA000, 32'h0000_0055, 32'h7, 0, 32'h0, 1, 2'd2,
                     32'hA000, 4'b1111, 32'h0000_0055, 32'h0};

        // Reset, with a valid aligned op presented to check gating of ready/stall
        valid = 1'b1;
        aluop = OpLw;
        addr  = 32'h100;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst data_req", {31'h0, data_req}, 32'h0);
        chk("rst data_wr", {31'h0, data_wr}, 32'h0);
        chk("rst data_size", {30'h0, data_size}, 32'h0);
        chk("rst data_addr", data_addr, 32'h0);
        chk("rst data_wstrb", {28'h0, data_wstrb}, 32'h0);
        chk("rst data_wdata", data_wdata, 32'h0);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst mem_data", mem_data, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst excepttype", excepttype, 32'h0);
        chk("rst sc_result", {31'h0, sc_result}, 32'h0);
        chk("rst ready", {31'h0, ready}, 32'h0);
        chk("rst stall", {31'h0, stall}, 32'h0);
        cyc();
        rst   = 1'b0;
        valid = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].rt);
            @(negedge clk);
            chk($sformatf("v%0d ready", i), {31'h0, ready}, 32'h1);
            chk($sformatf("v%0d stall", i), {31'h0, stall}, {31'h0, !vecs[i].mis});
            cyc();
            valid = 1'b0;
            if (!vecs[i].mis) begin
                addr_ok = 1'b1;
                data_ok = 1'b1;
                rdata   = vecs[i].rdata;
            end
            @(negedge clk);
            if (vecs[i].mis) begin
                chk($sformatf("v%0d no req", i), {31'h0, data_req}, 32'h0);
                chk($sformatf("v%0d exc resp", i), {31'h0, resp_valid}, 32'h1);
                chk($sformatf("v%0d excepttype", i), excepttype, vecs[i].exc);
                chk($sformatf("v%0d exc addr", i), mem_addr, vecs[i].addr);
            end else begin
                chk($sformatf("v%0d data_req", i), {31'h0, data_req}, 32'h1);
                chk($sformatf("v%0d data_wr", i), {31'h0, data_wr}, {31'h0, vecs[i].wr});
                chk($sformatf("v%0d size", i), {30'h0, data_size}, {30'h0, vecs[i].size});
                chk($sformatf("v%0d addr", i), data_addr, vecs[i].baddr);
                chk($sformatf("v%0d wstrb", i), {28'h0, data_wstrb}, {28'h0, vecs[i].wstrb});
                chk($sformatf("v%0d wdata", i), data_wdata, vecs[i].wdata);
                chk($sformatf("v%0d early resp", i), {31'h0, resp_valid}, 32'h0);
                cyc();
                addr_ok = 1'b0;
                data_ok = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d resp", i), {31'h0, resp_valid}, 32'h1);
                chk($sformatf("v%0d mem_data", i), mem_data, vecs[i].mdata);
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
                chk($sformatf("v%0d exc none", i), excepttype, 32'h0);
                chk($sformatf("v%0d req drop", i), {31'h0, data_req}, 32'h0);
                if (vecs[i].op == OpSc)
                    chk($sformatf("v%0d sc_result", i), {31'h0, sc_result}, 32'h1);
            end
        end

        // Slow bus: addr_ok after 3 wait cycles, data_ok two cycles later
        issue(OpLw, 32'h2000, 32'h0);
        @(negedge clk);
        chk("slow ready", {31'h0, ready}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            valid   = 1'b0;
            addr_ok = (k == 3);
            @(negedge clk);
            chk($sformatf("slow req%0d", k), {31'h0, data_req}, 32'h1);
            chk($sformatf("slow stall%0d", k), {31'h0, stall}, 32'h1);
        end
        cyc();
        addr_ok = 1'b0;
        @(negedge clk);
        chk("slow wait req", {31'h0, data_req}, 32'h0);
        chk("slow wait stall", {31'h0, stall}, 32'h1);
        cyc();
        data_ok = 1'b1;
        rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("slow dok stall", {31'h0, stall}, 32'h1);
        chk("slow dok resp", {31'h0, resp_valid}, 32'h0);
        cyc();
        data_ok = 1'b0;
        @(negedge clk);
        chk("slow resp", {31'h0, resp_valid}, 32'h1);
        chk("slow mem_data", mem_data, 32'hDEAD_BEEF);
        chk("slow stall clear", {31'h0, stall}, 32'h0);
        cyc();
        @(negedge clk);
        chk("slow resp pulse", {31'h0, resp_valid}, 32'h0);

        // Flush while waiting for data: response swallowed, next op accepted
        issue(OpLw, 32'h2004, 32'h0);
        cyc();
        valid   = 1'b0;
        addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        chk("wflush stall", {31'h0, stall}, 32'h1);
        cyc();
        flush   = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h77;
        @(negedge clk);
        chk("drain stall", {31'h0, stall}, 32'h1);
        cyc();
        data_ok = 1'b0;
        valid   = 1'b1;
        aluop   = OpSw;
        addr    = 32'h2008;
        reg2    = 32'h1234;
        @(negedge clk);
        chk("drain no resp", {31'h0, resp_valid}, 32'h0);
        chk("post-drain ready", {31'h0, ready}, 32'h1);
        cyc();
        valid   = 1'b0;
        addr_ok = 1'b1;
        data_ok = 1'b1;
        @(negedge clk);
        chk("post-drain req", {31'h0, data_req}, 32'h1);
        cyc();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        @(negedge clk);
        chk("post-drain resp", {31'h0, resp_valid}, 32'h1);

        // Flush in REQ before addr_ok drops the request
        issue(OpSw, 32'h2020, 32'h9);
        cyc();
        valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("rflush req held", {31'h0, data_req}, 32'h1);
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("rflush req drop", {31'h0, data_req}, 32'h0);
        chk("rflush stall", {31'h0, stall}, 32'h0);
        chk("rflush no resp", {31'h0, resp_valid}, 32'h0);
        cyc();
        @(negedge clk);
        chk("rflush no resp2", {31'h0, resp_valid}, 32'h0);

        // Flush alongside valid in IDLE: not accepted
        issue(OpLw, 32'h2030, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        chk("iflush ready", {31'h0, ready}, 32'h0);
        chk("iflush stall", {31'h0, stall}, 32'h0);
        cyc();
        valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("iflush no req", {31'h0, data_req}, 32'h0);
        chk("iflush no resp", {31'h0, resp_valid}, 32'h0);

        // Reset mid-transaction, then a late data_ok
        issue(OpLw, 32'h2010, 32'h0);
        cyc();
        valid   = 1'b0;
        addr_ok = 1'b1;
        cyc();
        addr_ok = 1'b0;
        rst     = 1'b1;
        cyc();
        rst     = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h1111;
        @(negedge clk);
        chk("mrst req", {31'h0, data_req}, 32'h0);
        chk("mrst stall", {31'h0, stall}, 32'h0);
        cyc();
        data_ok = 1'b0;
        @(negedge clk);
        chk("mrst late dok", {31'h0, resp_valid}, 32'h0);

        // SC with LLbit clear
        llbit = 1'b0;
        issue(OpSc, 32'hB000, 32'h66);
        @(negedge clk);
        chk("scf ready", {31'h0, ready}, 32'h1);
`ifdef DMEM_LLSC_EN
        chk("scf stall", {31'h0, stall}, 32'h0);
        cyc();
        valid = 1'b0;
        @(negedge clk);
        chk("scf no req", {31'h0, data_req}, 32'h0);
        chk("scf resp", {31'h0, resp_valid}, 32'h1);
        chk("scf result", {31'h0, sc_result}, 32'h0);
        chk("scf exc", excepttype, 32'h0);
`else
        chk("scf stall", {31'h0, stall}, 32'h1);
        cyc();
        valid   = 1'b0;
        addr_ok = 1'b1;
        data_ok = 1'b1;
        @(negedge clk);
        chk("scf req", {31'h0, data_req}, 32'h1);
        chk("scf wstrb", {28'h0, data_wstrb}, 32'hF);
        cyc();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        @(negedge clk);
        chk("scf resp", {31'h0, resp_valid}, 32'h1);
        chk("scf result", {31'h0, sc_result}, 32'h1);
`endif
        llbit = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_req.md
DMEM_REQ -- requirements
Module: dmem_req

Interface
REQ-001 Parameter: ALUOP_W, 8, width of aluop_i; SHALL match the core-wide aluop bus.
REQ-002 clk  in  1  core clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 valid_i  in  1  EX presents a memory op this cycle.
REQ-005 aluop_i  in  ALUOP_W  op: LB/LBU/LH/LHU/LW/LWL/LWR/LL/SB/SH/SW/SWL/SWR/SC (core aluop encodings).
REQ-006 addr_i  in  32  effective byte address; reg2_i  in  32  store data (rt).
REQ-007 llbit_i  in  1  current LLbit; flush_i  in  1  exception/flush from commit.
REQ-008 ready_o  out  1  op accepted this cycle; stall_o  out  1  pipeline stall request.
REQ-009 data_req_o  out  1; data_wr_o  out  1; data_size_o  out  2 (0 byte, 1 half, 2 word); data_addr_o  out  32; data_wstrb_o  out  4; data_wdata_o  out  32.
REQ-010 data_addr_ok_i  in  1  request accepted; data_data_ok_i  in  1  response; data_rdata_i  in  32  raw load word.
REQ-011 resp_valid_o  out  1; mem_data_o  out  32 (raw word to MEM stage); mem_addr_o  out  32; excepttype_o  out  32 (bit4 ADEL, bit5 ADES, others 0); sc_result_o  out  1.

Function
REQ-012 FSM states IDLE, REQ, WAIT, DRAIN; single outstanding transaction.
REQ-013 IDLE: valid_i & ~flush_i & aligned -> capture op/addr/data, ready_o=1, go REQ next cycle.
REQ-014 Misalignment: LH/LHU/SH with addr_i[0]=1, or LW/LL/SW/SC with addr_i[1:0]!=0 -> no bus request, ready_o=1, next cycle resp_valid_o=1 with excepttype_o bit4 (loads) or bit5 (stores), mem_addr_o=addr_i; state stays IDLE.
REQ-015 REQ: data_req_o=1 held with stable addr/wdata/wstrb until data_addr_ok_i; then WAIT. addr_ok and data_ok in same cycle -> straight to IDLE with response.
REQ-016 WAIT: on data_data_ok_i, register data_rdata_i into mem_data_o, pulse resp_valid_o for exactly one cycle (one cycle after data_ok), return IDLE.
REQ-017 stall_o=1 whenever state != IDLE or (valid_i in IDLE and a new request is starting).
REQ-018 Loads: data_wr_o=0, data_wstrb_o=0; size 0 for LB/LBU, 1 for LH/LHU, 2 otherwise; LWL/LWR address = {addr[31:2],2'b00}.
REQ-019 SB: wstrb=1<<addr[1:0], wdata={4{rt[7:0]}}. SH: wstrb 0011 (addr[1]=0) / 1100, wdata={2{rt[15:0]}}. SW/SC: wstrb 1111, wdata=rt.
REQ-020 SWL by addr[1:0] 00/01/10/11: wstrb 0001/0011/0111/1111, wdata {24'b0,rt[31:24]}/{16'b0,rt[31:16]}/{8'b0,rt[31:8]}/rt; word-aligned address, size 2.
REQ-021 SWR by addr[1:0] 00/01/10/11: wstrb 1111/1110/1100/1000, wdata rt/{rt[23:0],8'b0}/{rt[15:0],16'b0}/{rt[7:0],24'b0}.
REQ-022 flush_i in REQ before addr_ok: drop request (data_req_o low next cycle), IDLE, no resp. flush_i in WAIT: go DRAIN, absorb data_ok with no resp_valid_o, then IDLE.
REQ-023 flush_i with valid_i in IDLE: op not accepted, ready_o=0.
REQ-024 Stores complete on data_ok with resp_valid_o=1, mem_data_o=0.

Reset
REQ-025 rst SHALL force IDLE, data_req_o=0, data_wr_o=0, data_size_o=0, data_addr_o=0, data_wstrb_o=0, data_wdata_o=0, resp_valid_o=0, mem_data_o=0, mem_addr_o=0, excepttype_o=0, sc_result_o=0, ready_o=0, stall_o=0.
REQ-026 rst mid-transaction SHALL abandon it; a late data_ok after reset SHALL be ignored (no resp_valid_o).

Configuration
REQ-027 Macro DMEM_LLSC_EN: defined -> SC with llbit_i=0 issues no bus request, resp_valid_o next cycle with sc_result_o=0; llbit_i=1 stores word, sc_result_o=1 on response. Undefined -> SC behaves as SW, sc_result_o=1 always; LL as LW in both cases.

Verification
REQ-028 SB addr 0x1003 rt=0x000000AB, addr_ok+data_ok immediate -> wstrb 1000, wdata 0xABABABAB, size 0, resp next cycle.
REQ-029 LW addr 0x2002 -> no data_req_o, resp_valid_o with excepttype_o=0x10, mem_addr_o=0x2002.
REQ-030 SWR addr 0x3001 rt=0x11223344 -> data_addr_o 0x3000, wstrb 1110, wdata 0x22334400.
REQ-031 LW, addr_ok delayed 3 cycles, data_ok 2 later rdata 0xDEADBEEF -> data_req_o held 4 cycles, stall_o high throughout, mem_data_o=0xDEADBEEF one cycle after data_ok.
REQ-032 LW accepted, flush_i in WAIT, data_ok next cycle -> no resp_valid_o, back to IDLE, next op accepted.
REQ-033 DMEM_LLSC_EN, SC with llbit_i=0 -> no bus request, sc_result_o=0; llbit_i=1 -> wstrb 1111, sc_result_o=1.
